// File: rtl/flt16_add_seq_if.sv
// ============================================================================
// Module   : flt16_add_seq_if
// Brief    : Start/done handshake and operand/result bundle for flt16_add_seq.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface flt16_add_seq_if;
    logic        start;
    logic [15:0] a_i;
    logic [15:0] b_i;
    logic        busy;
    logic        done;
    logic [15:0] sum_o;

    modport master (output start, a_i, b_i, input busy, done, sum_o);
    modport slave  (input start, a_i, b_i, output busy, done, sum_o);
endinterface

`default_nettype wire

// File: rtl/flt16_add_seq.sv
// ============================================================================
// Module   : flt16_add_seq
// Brief    : Multi-cycle binary16 add/subtract, one alignment bit per cycle.
//            Optional round-to-nearest-even via macro FLT16_ADD_RND_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module flt16_add_seq #(
    parameter int MAX_ALIGN = 14
) (
    input  wire logic       clk,
    input  wire logic       reset,
    flt16_add_seq_if.slave  bus
);

`ifdef FLT16_ADD_RND_EN
    localparam int c_EXT = 3;
`else
    localparam int c_EXT = 0;
`endif
    localparam int         c_MW        = 11 + c_EXT;
    localparam logic [4:0] c_MAX_ALIGN = 5'(MAX_ALIGN);

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_ALIGN, S_ADDSUB, S_NORM, S_PACK, S_PACK2, S_DONE
    } state_t;

    state_t          r_state;
    logic [15:0]     r_a, r_b;
    logic            r_sx, r_sy, r_sign;
    logic [5:0]      r_ex;
    logic [c_MW-1:0] r_mx, r_my;
    logic [c_MW:0]   r_sum;
    logic [4:0]      r_d;
    logic            r_busy, r_done;
    logic [15:0]     r_sum_o;

    // Operand X is always the larger magnitude, so subtraction never goes negative
    logic            w_swap;
    logic [15:0]     w_x, w_y;
    logic [4:0]      w_ex_eff, w_ey_eff;
    logic [c_MW-1:0] w_mx_new, w_my_new, w_my_shr, w_my_clr;
    logic [c_MW:0]   w_sum, w_sum_shr;
    logic [10:0]     w_mant11;
    logic [15:0]     w_packed;

    assign w_swap   = (r_b[14:0] > r_a[14:0]);
    assign w_x      = w_swap ? r_b : r_a;
    assign w_y      = w_swap ? r_a : r_b;
    assign w_ex_eff = (w_x[14:10] == 5'd0) ? 5'd1 : w_x[14:10];
    assign w_ey_eff = (w_y[14:10] == 5'd0) ? 5'd1 : w_y[14:10];
    assign w_mx_new = c_MW'({|w_x[14:10], w_x[9:0]}) << c_EXT;
    assign w_my_new = c_MW'({|w_y[14:10], w_y[9:0]}) << c_EXT;
    assign w_sum    = (r_sx == r_sy) ? ({1'b0, r_mx} + {1'b0, r_my})
                                     : ({1'b0, r_mx} - {1'b0, r_my});

`ifdef FLT16_ADD_RND_EN
    // Bit 0 is sticky: every bit shifted past it is folded in
    assign w_my_shr  = {1'b0, r_my[c_MW-1:2], |r_my[1:0]};
    assign w_my_clr  = {{(c_MW-1){1'b0}}, |r_my};
    assign w_sum_shr = {1'b0, r_sum[c_MW:2], |r_sum[1:0]};

    logic        w_rnd_up;
    logic [11:0] w_rm;
    assign w_rnd_up = r_sum[2] & (r_sum[1] | r_sum[0] | r_sum[3]);
    assign w_rm     = {1'b0, r_sum[c_MW-1:c_EXT]} + {11'd0, w_rnd_up};
`else
    assign w_my_shr  = r_my >> 1;
    assign w_my_clr  = '0;
    assign w_sum_shr = r_sum >> 1;
`endif

    assign w_mant11 = r_sum[c_MW-1:c_EXT];
    assign w_packed = (r_ex >= 6'd31) ? {r_sign, 5'h1F, 10'h000}
                    : {r_sign, (w_mant11[10] ? r_ex[4:0] : 5'd0), w_mant11[9:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum_o <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a_i;
                        r_b     <= bus.b_i;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_sx    <= w_x[15];
                    r_sy    <= w_y[15];
                    r_ex    <= {1'b0, w_ex_eff};
                    r_mx    <= w_mx_new;
                    r_my    <= w_my_new;
                    r_d     <= w_ex_eff - w_ey_eff;
                    r_state <= (w_ex_eff == w_ey_eff) ? S_ADDSUB : S_ALIGN;
                end
                S_ALIGN: begin
                    if (r_d >= c_MAX_ALIGN) begin
                        r_my    <= w_my_clr;
                        r_state <= S_ADDSUB;
                    end else begin
                        r_my <= w_my_shr;
                        r_d  <= r_d - 5'd1;
                        if (r_d == 5'd1)
                            r_state <= S_ADDSUB;
                    end
                end
                S_ADDSUB: begin
                    r_sum   <= w_sum;
                    r_sign  <= (w_sum == '0) ? 1'b0 : r_sx;
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_sum[c_MW]) begin
                        r_sum <= w_sum_shr;
                        r_ex  <= r_ex + 6'd1;
                    end else if (!r_sum[c_MW-1] && (r_sum != '0) && (r_ex > 6'd1)) begin
                        r_sum <= r_sum << 1;
                        r_ex  <= r_ex - 6'd1;
                    end else begin
                        r_state <= S_PACK;
                    end
                end
                S_PACK: begin
`ifdef FLT16_ADD_RND_EN
                    r_sum   <= {1'b0, (w_rm[11] ? w_rm[11:1] : w_rm[10:0]), 3'b000};
                    r_ex    <= r_ex + {5'd0, w_rm[11]};
                    r_state <= S_PACK2;
`else
                    r_sum_o <= w_packed;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
`endif
                end
                S_PACK2: begin
                    r_sum_o <= w_packed;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.sum_o = r_sum_o;

endmodule

`default_nettype wire
